// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 27;
    localparam int unsigned DEFAULT_INST_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH_WAIT
    } fetch_state_t;

    // Prefetch queue entry: instruction tagged with its fetch address
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
        logic [DEFAULT_INST_W-1:0] inst;
    } queue_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Redirect, flash read handshake and IF/ID delivery signals of the fetch unit.
interface inst_fetch_unit_if #(
    parameter int unsigned ADDR_W = fetch_pkg::DEFAULT_ADDR_W,
    parameter int unsigned INST_W = fetch_pkg::DEFAULT_INST_W
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              flash_req;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_ack;
    logic [INST_W-1:0] flash_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        input  redirect_valid, redirect_addr, flash_ack, flash_data, inst_ready,
        output flash_req, flash_addr, inst_valid, inst_out, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_addr, flash_ack, flash_data, inst_ready,
        input  flash_req, flash_addr, inst_valid, inst_out, inst_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched instructions; flush empties it in one cycle.
module fetch_queue #(
    parameter int unsigned WIDTH = 59,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is cleared on reset so the head never reads X
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns fetch_pc, issues flash word reads and
// buffers returned instructions (tagged with their address) toward IF/ID.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned       INST_W     = DEFAULT_INST_W,
    parameter int unsigned       DEPTH      = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    inst_fetch_unit_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
    logic              flash_req_q, flash_req_d;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    count_after;
    entry_t            push_entry;
    entry_t            head;

    // A redirect hides the head and empties the queue in the same cycle
    assign pop            = !empty && bus.inst_ready && !bus.redirect_valid;
    assign bus.inst_valid = !empty && !bus.redirect_valid;
    assign bus.inst_out   = head.inst;
    assign bus.inst_pc    = head.pc;
    assign bus.flash_req  = flash_req_q;
    assign bus.flash_addr = flash_addr_q;

    fetch_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .push_data (push_entry),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_ADDR;
            flash_req_q  <= 1'b0;
            flash_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            flash_req_q  <= flash_req_d;
            flash_addr_q <= flash_addr_d;
        end
    end

    // Next-state: a request, once raised, is only dropped after its ack
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        flash_req_d     = flash_req_q;
        flash_addr_d    = flash_addr_q;
        push            = 1'b0;
        push_entry.pc   = fetch_pc_q;
        push_entry.inst = bus.flash_data;
        count_after     = (CNT_W + 1)'(count) + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);

        unique case (state_q)
            IDLE: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = bus.redirect_addr;
                end else if (!full) begin
                    flash_req_d  = 1'b1;
                    flash_addr_d = fetch_pc_q;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = bus.redirect_addr;
                    if (bus.flash_ack) begin
                        flash_req_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = FLUSH_WAIT;
                    end
                end else if (bus.flash_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    if (count_after < (CNT_W + 1)'(DEPTH)) begin
                        flash_addr_d = fetch_pc_q + ADDR_W'(1);
                    end else begin
                        flash_req_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            FLUSH_WAIT: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = bus.redirect_addr;
                end
                if (bus.flash_ack) begin
                    flash_req_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                flash_req_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch front end sitting between the program counter/flash pair and the IF/ID register. It owns the fetch address, issues word reads to flash over a req/ack handshake with variable latency, and buffers returned instructions, each tagged with its address, in a small prefetch queue. A redirect from the control unit (taken branch/jump) flushes the queue and discards any in-flight read.

Parameters:
ADDR_W, 27, fetch/PC address width (word address, increments by 1)
INST_W, 32, instruction width
DEPTH, 4, prefetch queue entries (power of 2, >= 2)
RESET_ADDR, 0, fetch address loaded on reset

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  load new fetch address this cycle (taken branch/jump)
redirect_addr  in  ADDR_W  new fetch address
flash_req  out  1  read request, held high until flash_ack
flash_addr  out  ADDR_W  read address, stable while flash_req high
flash_ack  in  1  one-cycle pulse, flash_data valid this cycle
flash_data  in  INST_W  returned instruction word
inst_valid  out  1  queue head valid toward IF/ID
inst_out  out  INST_W  queue head instruction
inst_pc  out  ADDR_W  address of inst_out
inst_ready  in  1  downstream accepts head this cycle

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_ADDR, queue empty, inflight=0, state=IDLE, flash_req=0, flash_addr=0, inst_valid=0, inst_out=0, inst_pc=0. Reset mid-request: request dropped immediately; a flash_ack arriving after reset is ignored.
- FSM states: IDLE, REQ, FLUSH_WAIT.
- IDLE: if count < DEPTH and no redirect, assert flash_req with flash_addr=fetch_pc next cycle, go REQ. Redirect in IDLE: fetch_pc<=redirect_addr, stay IDLE; issue on the following cycle.
- REQ: flash_req held, flash_addr constant. On flash_ack without redirect: push {fetch_pc, flash_data}; fetch_pc<=fetch_pc+1 (wraps modulo 2^ADDR_W). If the queue still has room after push/pop accounting, the next request issues back-to-back: flash_req stays high and flash_addr updates; otherwise go IDLE.
- Redirect in REQ without ack: fetch_pc<=redirect_addr, go FLUSH_WAIT; flash_req stays high with the OLD flash_addr (protocol: no request withdrawal).
- Redirect in the same cycle as flash_ack: data discarded, fetch_pc<=redirect_addr, go IDLE.
- FLUSH_WAIT: on flash_ack, discard the data and go IDLE. A further redirect here overwrites fetch_pc and stays in FLUSH_WAIT.
- Queue: at most one request in flight, so a push only occurs when count < DEPTH. Pop when inst_valid & inst_ready. Push and pop in the same cycle leave count unchanged.
- Redirect priority: in a redirect cycle, inst_valid is forced 0 combinationally, no pop occurs, and count=0 next cycle.
- Outputs inst_out/inst_pc are driven from the head entry. Their value is don't-care when inst_valid=0 but must not be X after reset.
- Throughput: with zero-wait flash (ack the cycle after req) and inst_ready=1, one instruction per cycle is sustained after 2-cycle initial latency (reset release to first inst_valid).

Decomposition:
- fetch_pkg: ADDR_W, INST_W, DEPTH defaults, fetch_state_t enum {IDLE, REQ, FLUSH_WAIT}, queue entry struct {pc, inst}.
- Sub-module fetch_queue: synchronous FIFO with DEPTH entries and ports push, pop, flush, full, empty, count, head. inst_fetch_unit holds the FSM, fetch_pc and request registers.

Test Plan:
- Reset release, flash acks 1 cycle after each req with data=addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0,1,2,3..., one per cycle after the first; inst_out matches.
- inst_ready=0 and acks immediate -> exactly 4 requests issued (addr 0..3), flash_req low afterwards. Raise inst_ready -> pops 0..3 in order, fetching resumes at 4.
- Flash latency 5 cycles; redirect_valid to addr 0x100 two cycles after req for addr 2 -> flash_addr stays 2 until ack, data discarded, next flash_addr=0x100, first inst_pc after that =0x100, queue contains no entry for pc 2.
- redirect to 0x40 in the same cycle as flash_ack with a non-empty queue -> inst_valid=0 that cycle, queue empty next cycle, next request addr 0x40.
- fetch_pc=2^27-1, ack -> next flash_addr=0 (wrap).
- reset asserted while flash_req high and latency 3 -> flash_req=0 next cycle; late ack ignored; fetch restarts at RESET_ADDR.
